md_exception_ctrl: RTL and testbench
====================================

Name: md_exception_ctrl

Overview:
- Multi-cycle multiply/divide sequencer and exception generator for the execute (DX/X) stage of the 5-stage processor.
- Detects MUL/DIV ALU instructions, launches the shared mult/div unit and stalls the pipeline until the result is ready.
- Captures the result and unit exception flag, then emits a one-cycle result/exception beat with a parametrised exception code for the writeback/$rstatus path.
- Adds a watchdog timeout code for a hung unit and flush/abort handling.

Parameters:
- INSTR_W, 32, instruction width
- DATA_W, 32, result width
- CODE_W, 3, exception code width
- MUL_OP, 5'b00110, ALU opcode for multiply (instr[6:2])
- DIV_OP, 5'b00111, ALU opcode for divide
- MUL_CODE, 4, exception code for multiply overflow
- DIV_CODE, 5, exception code for divide error
- TO_CODE, 6, exception code for watchdog timeout
- TIMEOUT, 40, max busy cycles before timeout (>=2)

Ports:
- clock, input, 1, rising-edge clock
- reset, input, 1, asynchronous active-high reset
- instr, input, INSTR_W, instruction currently in execute
- issue, input, 1, instr is valid in execute this cycle
- flush, input, 1, squash in-flight operation (branch/jump)
- md_ready, input, 1, mult/div unit result ready
- md_exception, input, 1, mult/div unit exception flag
- md_result, input, DATA_W, mult/div unit result
- start_mul, output, 1, one-cycle launch pulse to multiplier
- start_div, output, 1, one-cycle launch pulse to divider
- stall, output, 1, freeze F/D/X pipeline registers
- busy, output, 1, operation in flight
- result, output, DATA_W, captured result
- rd, output, 5, destination register of the completed op
- result_valid, output, 1, one-cycle completion beat
- exception, output, CODE_W, exception code (0 = none)
- exc_valid, output, 1, exception is nonzero on the completion beat

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counter 0; latched opcode/rd cleared.
- MD op decode: instr[31:27]==5'b00000 AND instr[6:2] in {MUL_OP, DIV_OP}. All other instructions are ignored.
- IDLE:
  - On issue & MD op & ~flush: assert start_mul or start_div combinationally in that same cycle, and assert stall that cycle.
  - Latch op type and rd=instr[26:22].
  - Next state: BUSY; counter=0.
- BUSY:
  - stall=1, busy=1; counter increments each cycle.
  - md_ready=1: latch md_result; exception = md_exception ? (MUL_CODE or DIV_CODE per latched op) : 0; next state DONE.
  - Otherwise, counter==TIMEOUT-1: result=0, exception=TO_CODE; next state DONE.
  - md_ready and timeout in the same cycle: md_ready wins.
  - The start_* pulses are never re-asserted while in BUSY.
- DONE (exactly 1 cycle):
  - result_valid=1; exc_valid=(exception!=0); stall=0.
  - The held instruction advances. issue is ignored in this cycle. Next state IDLE.
  - result, rd and exception hold until the next completion or reset. result_valid and exc_valid are low outside DONE.
- flush in BUSY or DONE: next state IDLE. No result_valid or exc_valid beat. Counter cleared. flush in IDLE suppresses launch.
- Latency: issue cycle T; md_ready at T+k (k>=1) -> result_valid at T+k+1. Minimum 2 cycles issue-to-completion.
- Counter width = clog2(TIMEOUT); it never wraps.
- The module assumes the unit raises md_ready for one cycle. md_ready outside BUSY is ignored.

Decomposition:
- Shared package md_pkg:
  - exception code constants (MUL_CODE, DIV_CODE, TO_CODE, NONE=0)
  - ALU opcode constants, R-type opcode 5'b00000
  - state encoding IDLE/BUSY/DONE (2 bits)
- One sub-module: md_watchdog (counter with clear, enable and terminal-count flag, parametrised by TIMEOUT).

Test Plan:
- MUL issue (instr opcode 0, aluop 00110, rd=5); md_ready at +3 with result 42, no exception -> start_mul 1 pulse; stall high 4 cycles; result_valid with result=42, rd=5, exception=0, exc_valid=0.
- DIV with md_ready at +2 and md_exception=1 -> exception=5, exc_valid=1 for exactly one cycle, result_valid=1.
- MUL overflow (md_exception=1) -> exception=4.
- DIV with md_ready never asserted, TIMEOUT=40 -> exception=6 after the 40th busy cycle; stall drops the cycle after.
- flush 2 cycles into BUSY -> returns to IDLE; no result_valid or exc_valid; the next MUL launches normally. Reset asserted mid-BUSY -> all outputs 0 immediately (asynchronous).
- ADD (aluop 00000) and non-R-type with aluop bits 00110 -> no start pulse, stall=0, state stays IDLE.

Source files
------------

// File: rtl/md_pkg.sv
// Shared constants and state/op encodings for the multiply/divide exception
// sequencer in the execute stage.
package md_pkg;

  localparam logic [4:0] RTYPE_OP  = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam int EXC_NONE    = 0;
  localparam int EXC_MUL     = 4;
  localparam int EXC_DIV     = 5;
  localparam int EXC_TIMEOUT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

endpackage

// File: rtl/md_watchdog.sv
// Busy-cycle counter: clears to zero, counts while enabled and saturates at
// TIMEOUT-1, which is reported as the terminal-count flag.
module md_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_reg;

  assign terminal = (count_reg == CNT_W'(TIMEOUT - 1));

  // Holding at terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !terminal) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/md_exception_ctrl.sv
// Execute-stage MUL/DIV sequencer: launches the shared unit, stalls until a
// result or timeout, then emits a one-cycle result/exception beat.
module md_exception_ctrl
  import md_pkg::*;
#(
  parameter int         INSTR_W  = 32,
  parameter int         DATA_W   = 32,
  parameter int         CODE_W   = 3,
  parameter logic [4:0] MUL_OP   = ALUOP_MUL,
  parameter logic [4:0] DIV_OP   = ALUOP_DIV,
  parameter int         MUL_CODE = EXC_MUL,
  parameter int         DIV_CODE = EXC_DIV,
  parameter int         TO_CODE  = EXC_TIMEOUT,
  parameter int         TIMEOUT  = 40
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               issue,
  input  logic               flush,
  input  logic               md_ready,
  input  logic               md_exception,
  input  logic [DATA_W-1:0]  md_result,
  output logic               start_mul,
  output logic               start_div,
  output logic               stall,
  output logic               busy,
  output logic [DATA_W-1:0]  result,
  output logic [4:0]         rd,
  output logic               result_valid,
  output logic [CODE_W-1:0]  exception,
  output logic               exc_valid
);

  md_state_e         state_reg, state_next;
  md_op_e            op_reg;
  logic [4:0]        rd_pend_reg;
  logic [4:0]        rd_reg;
  logic [DATA_W-1:0] result_reg;
  logic [CODE_W-1:0] exc_reg;

  logic is_rtype, is_mul, is_div, launch;
  logic wd_clear, wd_enable, wd_tc;
  logic unused_instr;

  assign is_rtype     = (instr[31:27] == RTYPE_OP);
  assign is_mul       = is_rtype && (instr[6:2] == MUL_OP);
  assign is_div       = is_rtype && (instr[6:2] == DIV_OP);
  assign unused_instr = &{1'b0, instr[21:7], instr[1:0]};

  // Launch is combinational so the unit starts in the issue cycle itself.
  assign launch = (state_reg == IDLE) && issue && (is_mul || is_div) && !flush && !reset;

  // Counter is zero on BUSY entry and is cleared whenever BUSY is left.
  assign wd_clear  = (state_reg != BUSY) || (state_next != BUSY);
  assign wd_enable = (state_reg == BUSY);

  md_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .terminal(wd_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (launch) state_next = BUSY;
      BUSY: begin
        if (flush)                  state_next = IDLE;
        else if (md_ready || wd_tc) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_mul    = launch && is_mul;
    start_div    = launch && is_div;
    stall        = launch || (state_reg == BUSY);
    busy         = (state_reg == BUSY);
    result_valid = (state_reg == DONE) && !flush;
    exc_valid    = (state_reg == DONE) && !flush && (exc_reg != '0);
  end

  // rd is staged at launch and only published on completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_reg      <= OP_MUL;
      rd_pend_reg <= '0;
      rd_reg      <= '0;
      result_reg  <= '0;
      exc_reg     <= '0;
    end else begin
      if (launch) begin
        op_reg      <= is_div ? OP_DIV : OP_MUL;
        rd_pend_reg <= instr[26:22];
      end
      if (state_reg == BUSY && !flush) begin
        if (md_ready) begin
          result_reg <= md_result;
          rd_reg     <= rd_pend_reg;
          if (!md_exception)        exc_reg <= CODE_W'(EXC_NONE);
          else if (op_reg == OP_DIV) exc_reg <= CODE_W'(DIV_CODE);
          else                      exc_reg <= CODE_W'(MUL_CODE);
        end else if (wd_tc) begin
          result_reg <= '0;
          rd_reg     <= rd_pend_reg;
          exc_reg    <= CODE_W'(TO_CODE);
        end
      end
    end
  end

  assign result    = result_reg;
  assign rd        = rd_reg;
  assign exception = exc_reg;

endmodule

// File: tb/tb_md_exception_ctrl.sv
// Randomised self-checking bench for md_exception_ctrl against a timeline
// model of each MUL/DIV transaction.
module tb_md_exception_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        issue = 1'b0;
  logic        flush = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = '0;
  logic        start_mul, start_div, stall, busy, result_valid, exc_valid;
  logic [31:0] result;
  logic [4:0]  rd;
  logic [2:0]  exception;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prev_result = '0;
  logic [4:0]  prev_rd     = '0;
  logic [2:0]  prev_code   = '0;

  md_exception_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .issue       (issue),
    .flush       (flush),
    .md_ready    (md_ready),
    .md_exception(md_exception),
    .md_result   (md_result),
    .start_mul   (start_mul),
    .start_div   (start_div),
    .stall       (stall),
    .busy        (busy),
    .result      (result),
    .rd          (rd),
    .result_valid(result_valid),
    .exception   (exception),
    .exc_valid   (exc_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] md_instr(input bit is_div, input logic [4:0] rdv);
    logic [14:0] mid;
    mid = 15'($urandom);
    return {5'b00000, rdv, mid, (is_div ? 5'b00111 : 5'b00110), 2'b11};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [45:0] obs;
    reset = 1'b1;
    issue = 1'b1;
    instr = md_instr(1'b0, 5'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      obs = {start_mul, start_div, stall, busy, result_valid, exc_valid, exception, rd, result};
      n_checks++;
      if (obs !== 46'd0) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: got %h want 0", c, obs);
      end
    end
    next_cycle();
    reset = 1'b0;
    issue = 1'b0;
    $display("test_reset: outputs held at zero during reset");
  endtask

  task automatic test_md_ops(input int n_rand);
    bit          dir_div[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0]  dir_rd[5]   = '{5'd5, 5'd9, 5'd12, 5'd3, 5'd7};
    int          dir_k[5]    = '{3, 2, 1, 0, TIMEOUT};
    logic [31:0] dir_data[5] = '{32'd42, 32'hdead_0001, 32'h7fff_ffff, 32'h1111_2222, 32'hcafe_f00d};
    bit          dir_exc[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit          op_div, mexc, tmo, hit;
    logic [4:0]  rdv;
    logic [31:0] data, e_res;
    logic [2:0]  e_code;
    logic [45:0] obs, exp_v;
    int          k, done_c;
    for (int i = 0; i < 5 + n_rand; i++) begin
      if (i < 5) begin
        op_div = dir_div[i]; rdv = dir_rd[i]; k = dir_k[i];
        data = dir_data[i]; mexc = dir_exc[i];
      end else begin
        op_div = 1'($urandom_range(0, 1));
        rdv    = 5'($urandom);
        k      = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
        data   = $urandom;
        mexc   = 1'($urandom_range(0, 1));
      end
      // Completion lands the cycle after md_ready, or after TIMEOUT busy cycles.
      tmo    = (k == 0) || (k > TIMEOUT);
      done_c = tmo ? TIMEOUT + 1 : k + 1;
      e_res  = tmo ? 32'd0 : data;
      e_code = tmo ? 3'd6 : (mexc ? (op_div ? 3'd5 : 3'd4) : 3'd0);
      for (int c = 0; c <= done_c; c++) begin
        hit          = !tmo && (c == k);
        flush        = 1'b0;
        issue        = (c == 0 || c == done_c) ? 1'b1 : 1'($urandom_range(0, 1));
        instr        = (c == 0) ? md_instr(op_div, rdv) :
                       (c == done_c) ? md_instr(1'($urandom_range(0, 1)), 5'($urandom)) : $urandom;
        md_ready     = hit || ((c == 0 || c == done_c) && $urandom_range(0, 1) == 1);
        md_result    = hit ? data : $urandom;
        md_exception = hit ? mexc : 1'($urandom_range(0, 1));
        @(negedge clock);
        exp_v = {(c == 0) && !op_div, (c == 0) && op_div, c < done_c, (c >= 1) && (c < done_c),
                 c == done_c, (c == done_c) && (e_code != 3'd0),
                 (c == done_c) ? e_code : prev_code,
                 (c == done_c) ? rdv : prev_rd,
                 (c == done_c) ? e_res : prev_result};
        obs = {start_mul, start_div, stall, busy, result_valid, exc_valid, exception, rd, result};
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL md_op txn %0d cycle %0d: got %h want %h", i, c, obs, exp_v);
        end
        next_cycle();
      end
      prev_result = e_res;
      prev_rd     = rdv;
      prev_code   = e_code;
      $display("md_op txn %0d: %s rd=%0d ready_at=%0d exc_in=%0d -> result=%h code=%0d at cycle %0d",
               i, op_div ? "DIV" : "MUL", rdv, k, mexc, e_res, e_code, done_c);
    end
    issue    = 1'b0;
    md_ready = 1'b0;
  endtask

  task automatic test_non_md();
    logic [45:0] obs, exp_v;
    logic [4:0]  aluop;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        aluop = 5'b00000;
        instr = {5'b00000, 5'd4, 15'd0, aluop, 2'b11};
      end else if (c[0]) begin
        aluop = ($urandom_range(0, 1) == 1) ? 5'b00110 : 5'b00111;
        instr = {5'($urandom_range(1, 31)), 20'($urandom), aluop, 2'b11};
      end else begin
        aluop = 5'($urandom);
        if (aluop == 5'b00110 || aluop == 5'b00111) aluop = 5'b01000;
        instr = {5'b00000, 20'($urandom), aluop, 2'($urandom)};
      end
      issue    = 1'b1;
      flush    = 1'b0;
      md_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      exp_v = {6'b000000, prev_code, prev_rd, prev_result};
      obs   = {start_mul, start_div, stall, busy, result_valid, exc_valid, exception, rd, result};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL non_md cycle %0d instr %h: got %h want %h", c, instr, obs, exp_v);
      end
      next_cycle();
    end
    issue    = 1'b0;
    md_ready = 1'b0;
    $display("test_non_md: 12 non-MD issues ignored");
  endtask

  task automatic test_flush();
    logic [5:0]  e_ctl, ctl;
    logic [39:0] e_val, val;
    for (int c = 0; c <= 10; c++) begin
      issue = 1'b0; flush = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
      md_result = $urandom; instr = $urandom;
      e_ctl = 6'b000000;
      case (c)
        0:  begin issue = 1'b1; instr = md_instr(1'b0, 5'd10); e_ctl = 6'b101000; end
        1:  e_ctl = 6'b001100;
        2:  begin flush = 1'b1; e_ctl = 6'b001100; end
        4:  begin issue = 1'b1; flush = 1'b1; instr = md_instr(1'b0, 5'd13); end
        5:  begin issue = 1'b1; instr = md_instr(1'b0, 5'd11); e_ctl = 6'b101000; end
        6:  begin md_ready = 1'b1; md_result = 32'h1234; e_ctl = 6'b001100; end
        7:  e_ctl = 6'b000010;
        8:  begin issue = 1'b1; instr = md_instr(1'b1, 5'd2); e_ctl = 6'b011000; end
        9:  begin md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd77; e_ctl = 6'b001100; end
        10: flush = 1'b1;
        default: e_ctl = 6'b000000;
      endcase
      @(negedge clock);
      ctl = {start_mul, start_div, stall, busy, result_valid, exc_valid};
      n_checks++;
      if (ctl !== e_ctl) begin
        n_fail++;
        $display("FAIL flush cycle %0d: got ctl %b want %b", c, ctl, e_ctl);
      end
      if (c == 7) begin
        val   = {exception, rd, result};
        e_val = {3'd0, 5'd11, 32'h1234};
        n_checks++;
        if (val !== e_val) begin
          n_fail++;
          $display("FAIL flush_relaunch_result: got %h want %h", val, e_val);
        end
      end
      next_cycle();
    end
    flush = 1'b0;
    issue = 1'b0;
    $display("test_flush: flush in BUSY/DONE/IDLE and relaunch checked");
  endtask

  task automatic test_async_reset();
    logic [45:0] obs;
    issue = 1'b1;
    instr = md_instr(1'b1, 5'd21);
    next_cycle();
    issue = 1'b0;
    next_cycle();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_precondition: busy got %b want 1", busy);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {start_mul, start_div, stall, busy, result_valid, exc_valid, exception, rd, result};
    n_checks++;
    if (obs !== 46'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", obs);
    end
    next_cycle();
    reset       = 1'b0;
    prev_result = '0;
    prev_rd     = '0;
    prev_code   = '0;
    $display("test_async_reset: mid-BUSY reset cleared outputs before the next edge");
  endtask

  initial begin
    test_reset();
    test_md_ops(20);
    test_non_md();
    test_flush();
    test_async_reset();
    test_md_ops(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
